// File: rtl/next_pro_reader.sv
// Sweeps the next-hop and proposal SRAMs row by row after a batch finishes and
// serializes each row's lanes into a valid/ready stream while tracking proposal statistics.
module next_pro_reader #(
    parameter int Q               = 16,
    parameter int NEXT_BW         = 4,
    parameter int NEXT_ADDR_SPACE = 4,
    parameter int PRO_BW          = 8,
    parameter int PRO_ADDR_SPACE  = 4,
    parameter int ROWS            = 16,
    parameter int SKIP_ZERO       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 batch_num,
    output logic [NEXT_ADDR_SPACE-1:0] next_sram_raddr,
    input  logic [Q*NEXT_BW-1:0]       next_sram_rdata,
    output logic [PRO_ADDR_SPACE-1:0]  pro_sram_raddr,
    input  logic [Q*PRO_BW-1:0]        pro_sram_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_vid,
    output logic [NEXT_BW-1:0]         out_next,
    output logic [PRO_BW-1:0]          out_pro,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                pro_sum,
    output logic [PRO_BW-1:0]          pro_max
);

    localparam int LANE_W = (Q > 1) ? $clog2(Q) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(Q - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]           state;
    logic [ROW_W-1:0]     row;
    logic [LANE_W-1:0]    lane;
    logic [7:0]           batch_q;
    logic [Q*NEXT_BW-1:0] next_row_p1;
    logic [Q*PRO_BW-1:0]  pro_row_p1;

    logic [NEXT_BW-1:0] cur_next;
    logic [PRO_BW-1:0]  cur_pro;
    logic               eligible;
    logic               in_stream;
    logic               rd_phase;
    logic               lane_step;

    function automatic logic [15:0] sum_add(input logic [15:0] acc, input logic [PRO_BW-1:0] v);
        return acc + 16'(v);
    endfunction

    function automatic logic [PRO_BW-1:0] max_sel(input logic [PRO_BW-1:0] a, input logic [PRO_BW-1:0] b);
        return (b > a) ? b : a;
    endfunction

    assign cur_next  = next_row_p1[lane*NEXT_BW +: NEXT_BW];
    assign cur_pro   = pro_row_p1[lane*PRO_BW +: PRO_BW];
    assign eligible  = (SKIP_ZERO == 0) || (cur_pro != '0);
    assign in_stream = (state == S_STREAM);
    assign rd_phase  = (state == S_READ) || (state == S_WAIT);
    // Skipped lanes still take one cycle so every row costs the same time.
    assign lane_step = in_stream && (eligible ? out_ready : 1'b1);

    assign next_sram_raddr = rd_phase ? NEXT_ADDR_SPACE'(row) : '0;
    assign pro_sram_raddr  = rd_phase ? PRO_ADDR_SPACE'(row) : '0;

    assign out_valid = in_stream && eligible;
    assign out_vid   = out_valid ? {batch_q, 4'(row), 4'(lane)} : '0;
    assign out_next  = out_valid ? cur_next : '0;
    assign out_pro   = out_valid ? cur_pro : '0;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            row     <= '0;
            lane    <= '0;
            batch_q <= '0;
            pro_sum <= '0;
            pro_max <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_READ;
                        row     <= '0;
                        lane    <= '0;
                        batch_q <= batch_num;
                        pro_sum <= '0;
                        pro_max <= '0;
                    end
                end
                S_READ: state <= S_WAIT;
                S_WAIT: state <= S_STREAM;
                S_STREAM: begin
                    if (lane_step) begin
                        pro_sum <= sum_add(pro_sum, cur_pro);
                        pro_max <= max_sel(pro_max, cur_pro);
                        if (lane == LAST_LANE) begin
                            lane <= '0;
                            if (row == LAST_ROW) begin
                                state <= S_DONE;
                            end else begin
                                row   <= row + 1'b1;
                                state <= S_READ;
                            end
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Row capture: registered SRAM data is valid during WAIT.
    always_ff @(posedge clk) begin
        if (state == S_WAIT) begin
            next_row_p1 <= next_sram_rdata;
            pro_row_p1  <= pro_sram_rdata;
        end
    end

endmodule

// File: tb/tb_next_pro_reader.sv
// Randomized bench for next_pro_reader: SRAM models, a list-based reference of the
// expected stream and statistics, and per-batch timing/handshake checks.
module tb_next_pro_reader;

    localparam int Q       = 16;
    localparam int NEXT_BW = 4;
    localparam int PRO_BW  = 8;
    localparam int ROWS    = 16;
    localparam int LIMIT   = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 start;
    logic [7:0]           batch_num;
    logic [3:0]           next_raddr;
    logic [Q*NEXT_BW-1:0] next_rdata;
    logic [3:0]           pro_raddr;
    logic [Q*PRO_BW-1:0]  pro_rdata;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_vid;
    logic [NEXT_BW-1:0]   out_next;
    logic [PRO_BW-1:0]    out_pro;
    logic                 busy;
    logic                 done;
    logic [15:0]          pro_sum;
    logic [PRO_BW-1:0]    pro_max;

    next_pro_reader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .batch_num       (batch_num),
        .next_sram_raddr (next_raddr),
        .next_sram_rdata (next_rdata),
        .pro_sram_raddr  (pro_raddr),
        .pro_sram_rdata  (pro_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_vid         (out_vid),
        .out_next        (out_next),
        .out_pro         (out_pro),
        .busy            (busy),
        .done            (done),
        .pro_sum         (pro_sum),
        .pro_max         (pro_max)
    );

    logic [Q*NEXT_BW-1:0] next_mem [ROWS];
    logic [Q*PRO_BW-1:0]  pro_mem  [ROWS];

    always @(posedge clk) begin
        next_rdata <= next_mem[next_raddr];
        pro_rdata  <= pro_mem[pro_raddr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: {vid, next, pro} of every emitted lane in order, plus statistics.
    logic [27:0] exp_q[$];
    int          m_sum;
    int          m_max;

    task automatic build_model(input logic [7:0] bn);
        logic [7:0] p;
        logic [3:0] n;
        exp_q.delete();
        m_sum = 0;
        m_max = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int l = 0; l < Q; l++) begin
                p = pro_mem[r][l*PRO_BW +: PRO_BW];
                n = next_mem[r][l*NEXT_BW +: NEXT_BW];
                m_sum += int'(p);
                if (int'(p) > m_max) m_max = int'(p);
                if (p != 0) exp_q.push_back({bn, r[3:0], l[3:0], n, p});
            end
        end
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < ROWS; r++) begin
            for (int l = 0; l < Q; l++) begin
                case (mode)
                    0: begin next_mem[r][l*NEXT_BW +: NEXT_BW] = l[3:0]; pro_mem[r][l*PRO_BW +: PRO_BW] = 8'(l + 1); end
                    1: begin next_mem[r][l*NEXT_BW +: NEXT_BW] = l[3:0]; pro_mem[r][l*PRO_BW +: PRO_BW] = (r == 3) ? 8'd0 : 8'd1; end
                    2: begin next_mem[r][l*NEXT_BW +: NEXT_BW] = 4'($urandom); pro_mem[r][l*PRO_BW +: PRO_BW] = 8'd255; end
                    default: begin
                        next_mem[r][l*NEXT_BW +: NEXT_BW] = 4'($urandom);
                        pro_mem[r][l*PRO_BW +: PRO_BW] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                    end
                endcase
            end
        end
    endtask

    task automatic run_batch(input logic [7:0] bn, input bit rnd, input int pulse_a,
                             input int pulse_b, input int exp_xfers);
        int          cyc;
        int          done_cnt;
        int          done_cyc;
        int          xfers;
        bit          held_valid;
        logic [27:0] held;
        logic [27:0] e;
        build_model(bn);
        @(negedge clk);
        start = 1'b1; batch_num = bn; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; batch_num = ~bn;
        check("accept_sum", pro_sum, 0);
        check("accept_max", pro_max, 0);
        check("accept_busy", busy, 1);
        cyc = 1; done_cnt = 0; done_cyc = 0; xfers = 0; held_valid = 0; held = '0;
        while (cyc < LIMIT) begin
            start = (cyc == pulse_a) || (cyc == pulse_b);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (held_valid) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_vid, out_next, out_pro}, held);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_xfer", out_vid, 0);
                else begin
                    e = exp_q.pop_front();
                    check("xfer_vid", out_vid, e[27:12]);
                    check("xfer_next", out_next, e[11:8]);
                    check("xfer_pro", out_pro, e[7:0]);
                end
                xfers++;
                held_valid = 0;
            end else if (out_valid) begin
                held_valid = 1;
                held = {out_vid, out_next, out_pro};
            end else begin
                held_valid = 0;
                if (out_vid != 0 || out_pro != 0) check("idle_data", {out_vid, out_pro}, 0);
            end
            if (done_cnt > 0 && cyc == done_cyc + 2) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("done_count", done_cnt, 1);
        if (!rnd) check("done_cycle", done_cyc, ROWS * (2 + Q) + 1);
        check("xfer_count", xfers, exp_xfers);
        check("xfer_left", exp_q.size(), 0);
        check("sum", pro_sum, m_sum);
        check("max", pro_max, m_max);
        check("end_busy", busy, 0);
    endtask

    task automatic reset_mid_sweep();
        int cyc;
        int partial;
        build_model(8'h11);
        @(negedge clk);
        start = 1'b1; batch_num = 8'h11; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Row 7 streams during cycles 129..144; stop after six lanes.
        for (cyc = 1; cyc < 135; cyc++) @(negedge clk);
        partial = 0;
        for (int k = 0; k < 7 * Q + 6; k++) partial += (k % Q) + 1;
        check("pre_reset_sum", pro_sum, partial);
        check("pre_reset_vid", out_vid, 16'h1176);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sum", pro_sum, 0);
        check("rst_max", pro_max, 0);
        check("rst_done", done, 0);
        check("rst_raddr", next_raddr, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) check("post_rst_idle", {done, busy}, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; batch_num = 8'h00; out_ready = 1'b0;
        fill(0);
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", out_valid, 0);
        check("reset_sum", pro_sum, 0);
        check("reset_max", pro_max, 0);
        check("reset_raddr", {next_raddr, pro_raddr}, 0);
        rst_n = 1'b1;

        fill(0);
        run_batch(8'h2A, 1'b0, -1, -1, 256);
        check("t1_sum", pro_sum, 2176);
        check("t1_max", pro_max, 16);

        fill(1);
        run_batch(8'h07, 1'b0, -1, -1, 240);
        check("skip_sum", pro_sum, 240);

        fill(0);
        run_batch(8'h3C, 1'b1, -1, -1, 256);
        check("rnd_ready_sum", pro_sum, 2176);

        fill(0);
        run_batch(8'h44, 1'b0, 100, ROWS * (2 + Q) + 1, 256);

        fill(0);
        reset_mid_sweep();
        run_batch(8'h5C, 1'b0, -1, -1, 256);

        fill(2);
        run_batch(8'hFF, 1'b0, -1, -1, 256);
        check("full_sum", pro_sum, 65280);
        check("full_max", pro_max, 255);

        for (int t = 0; t < 3; t++) begin
            fill(3);
            build_model(8'h00);
            run_batch(8'(8'h80 + t), 1'b1, 50 + t, -1, exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
